// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Synchronises and debounces a raw push-button; emits level, press/release pulses and a press count.
// Optional long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = 240000,
    parameter int LONG_CYCLES   = 12000000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_raw,
    output logic                     btn_level,
    output logic                     btn_press,
    output logic                     btn_release,
    output logic [PRESS_COUNT_W-1:0] press_count,
    output logic                     long_press
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic btn_in;
    logic btn_s;

    assign btn_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Reset value 0 means "not pressed" after the optional inversion.
    sync_2ff #(
        .RESET_VAL(1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    btn_state_e       state;
    btn_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept_press;
    logic             accept_release;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = PRESSED;
                    accept_press = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt      = IDLE;
                    accept_release = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_press   <= accept_press;
            btn_release <= accept_release;
            if (accept_press) begin
                btn_level   <= 1'b1;
                press_count <= press_count + PRESS_COUNT_W'(1);
            end else if (accept_release) begin
                btn_level <= 1'b0;
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;

    // Only a fresh press clears the hold count; release bounce back into PRESSED keeps it running.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (accept_press) begin
                hold_cnt <= '0;
            end else if (btn_level && !accept_release && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    long_press <= 1'b1;
                end
            end
        end
    end
`else
    localparam int unused_long_cycles = LONG_CYCLES;

    assign long_press = 1'b0;
`endif

endmodule
